// File: rtl/uart_tx_framer.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Bit timing comes from an internal per-bit cycle counter; all outputs are registered.
module uart_tx_framer #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    localparam logic [7:0] CYC_LAST  = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    state_t     state;
    logic [7:0] cyc_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       par_bit;

    wire bit_end = (cyc_cnt == CYC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_start) begin
                        shreg   <= tx_data;
                        par_bit <= (PARITY == 2) ? ~(^tx_data) : (^tx_data);
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            tx      <= (PARITY != 0) ? par_bit : 1'b1;
                            state   <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            // tx is registered, so present the bit that lands in shreg[0] after this shift
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                PAR: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= STOP;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: four instances cover no/even/odd parity and two stop bits;
// a per-instance receiver monitor decodes each frame and checks it against queued expectations.
module tb_uart_tx_framer;

    localparam int CPB = 4;
    localparam int PAR_CFG  [4] = '{0, 1, 2, 0};
    localparam int STOP_CFG [4] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_start_v [4];
    logic [7:0] tx_data_v  [4];
    logic       tx_v       [4];
    logic       busy_v     [4];
    logic       done_v     [4];

    // entry: {back_to_back, expected_parity_bit, data}
    logic [9:0] exp_q [4][$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    for (genvar g = 0; g < 4; g++) begin : inst
        localparam int PB = PAR_CFG[g];
        localparam int SB = STOP_CFG[g];
        localparam int NB = 10 + ((PB != 0) ? 1 : 0) + (SB - 1);
        localparam int F  = CPB * NB;

        uart_tx_framer #(
            .CLKS_PER_BIT(CPB),
            .PARITY(PB),
            .STOP_BITS(SB)
        ) dut (
            .clk(clk),
            .reset(reset),
            .tx_start(tx_start_v[g]),
            .tx_data(tx_data_v[g]),
            .tx(tx_v[g]),
            .tx_busy(busy_v[g]),
            .tx_done(done_v[g])
        );

        logic        active = 1'b0;
        int          k = 0;
        int          busy_cnt = 0;
        int          since_done = 1000;
        logic [15:0] s = '0;
        logic        glitch = 1'b0;
        logic [9:0]  cur = '0;
        logic [7:0]  rx_byte;
        logic        stop_ok;

        always @(negedge clk) begin
            if (reset) begin
                active     = 1'b0;
                since_done = 1000;
            end else begin
                since_done++;
                if (!active && tx_v[g] == 1'b0) begin
                    if (exp_q[g].size() == 0) begin
                        chk($sformatf("inst%0d unexpected_frame", g), 1, 0);
                    end else begin
                        cur      = exp_q[g].pop_front();
                        active   = 1'b1;
                        k        = 0;
                        busy_cnt = 0;
                        glitch   = 1'b0;
                        s        = '0;
                        if (cur[9]) chk($sformatf("inst%0d b2b_gap", g), since_done, 1);
                    end
                end
                if (active) begin
                    if (k < F) begin
                        if (k % CPB == 0) s[k / CPB] = tx_v[g];
                        else if (tx_v[g] !== s[k / CPB]) glitch = 1'b1;
                        if (busy_v[g]) busy_cnt++;
                        if (done_v[g]) chk($sformatf("inst%0d early_done", g), 1, 0);
                        k++;
                    end else begin
                        for (int i = 0; i < 8; i++) rx_byte[i] = s[i + 1];
                        stop_ok = 1'b1;
                        for (int j = 0; j < SB; j++)
                            if (s[9 + ((PB != 0) ? 1 : 0) + j] !== 1'b1) stop_ok = 1'b0;
                        chk($sformatf("inst%0d start_bit", g), s[0], 0);
                        chk($sformatf("inst%0d data", g), rx_byte, cur[7:0]);
                        if (PB != 0) chk($sformatf("inst%0d parity", g), s[9], cur[8]);
                        chk($sformatf("inst%0d stop_bits", g), stop_ok, 1);
                        chk($sformatf("inst%0d bit_steady", g), glitch, 0);
                        chk($sformatf("inst%0d busy_len", g), busy_cnt, F);
                        chk($sformatf("inst%0d done_at_end", g), done_v[g], 1);
                        chk($sformatf("inst%0d busy_fall", g), busy_v[g], 0);
                        active     = 1'b0;
                        since_done = 0;
                    end
                end else if (done_v[g]) begin
                    chk($sformatf("inst%0d stray_done", g), 1, 0);
                end
            end
        end
    end

    task automatic pulse(input logic [3:0] mask);
        for (int i = 0; i < 4; i++) if (mask[i]) tx_start_v[i] = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) tx_start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (done_v[g]) seen = 1;
        end
        if (!seen) chk($sformatf("inst%0d done_timeout", g), 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            tx_start_v[i] = 1'b0;
            tx_data_v[i]  = 8'h00;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("inst%0d reset_tx", i), tx_v[i], 1);
            chk($sformatf("inst%0d reset_busy", i), busy_v[i], 0);
            chk($sformatf("inst%0d reset_done", i), done_v[i], 0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // basic frame 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1
        tx_data_v[0] = 8'hA5;
        exp_q[0].push_back({1'b0, 1'b0, 8'hA5});
        pulse(4'b0001);
        chk("inst0 accept_tx", tx_v[0], 0);
        chk("inst0 accept_busy", busy_v[0], 1);
        wait_done(0, 100);
        repeat (2) @(posedge clk); #1;

        // 0x07: even parity bit 1, odd parity bit 0; two stop bits with 0x00
        tx_data_v[1] = 8'h07; exp_q[1].push_back({1'b0, 1'b1, 8'h07});
        tx_data_v[2] = 8'h07; exp_q[2].push_back({1'b0, 1'b0, 8'h07});
        tx_data_v[3] = 8'h00; exp_q[3].push_back({1'b0, 1'b0, 8'h00});
        pulse(4'b1110);
        wait_done(3, 100);
        repeat (2) @(posedge clk); #1;

        // back-to-back with tx_start held; data changes during the first frame
        exp_q[0].push_back({1'b0, 1'b0, 8'h55});
        exp_q[0].push_back({1'b1, 1'b0, 8'h3C});
        tx_data_v[0]  = 8'h55;
        tx_start_v[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        tx_data_v[0] = 8'h3C;
        wait_done(0, 100);
        @(posedge clk); #1;
        tx_start_v[0] = 1'b0;
        wait_done(0, 100);
        repeat (2) @(posedge clk); #1;

        // request while busy is dropped
        tx_data_v[0] = 8'hC3;
        exp_q[0].push_back({1'b0, 1'b0, 8'hC3});
        pulse(4'b0001);
        repeat (15) @(posedge clk);
        #1;
        tx_data_v[0] = 8'hFF;
        pulse(4'b0001);
        wait_done(0, 100);
        repeat (60) @(posedge clk);
        #1;
        chk("inst0 idle_tx", tx_v[0], 1);
        chk("inst0 idle_busy", busy_v[0], 0);

        // reset during data bit 3 (cycles 17..20 after the accept edge)
        tx_data_v[0] = 8'h81;
        exp_q[0].push_back({1'b0, 1'b0, 8'h81});
        pulse(4'b0001);
        repeat (17) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("inst0 midreset_tx", tx_v[0], 1);
        chk("inst0 midreset_busy", busy_v[0], 0);
        chk("inst0 midreset_done", done_v[0], 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("inst0 postreset_done", done_v[0], 0);
        chk("inst0 postreset_busy", busy_v[0], 0);
        tx_data_v[0] = 8'h4E;
        exp_q[0].push_back({1'b0, 1'b0, 8'h4E});
        pulse(4'b0001);
        wait_done(0, 100);
        repeat (3) @(posedge clk); #1;

        for (int i = 0; i < 4; i++) chk($sformatf("inst%0d queue_empty", i), exp_q[i].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
